full_adder_unit: RTL and testbench

- Registered ripple-carry adder. Adds two WIDTH-bit operands and a carry-in; produces a WIDTH-bit sum and a carry-out.
- With the default WIDTH=1 it is the classic single-bit full adder (a, b, cin -> sum, carry), with registered outputs.
- Used as a leaf arithmetic block wherever a small clocked adder with a valid qualifier is needed.

---
 rtl/full_adder_unit_pkg.sv | 18 +
 rtl/full_adder_unit_fa_bit.sv | 22 ++
 rtl/full_adder_unit.sv | 65 ++++++
 tb/tb_full_adder_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/full_adder_unit_pkg.sv
// ============================================================================
// full_adder_unit_pkg : shared constants and bit-level helpers for the adder
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package full_adder_unit_pkg;

  localparam int unsigned C_MAX_WIDTH = 64;

  // Carry-out of one full-adder cell: majority of the three inputs.
  function automatic logic fa_majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_unit_fa_bit.sv
// ============================================================================
// fa_bit : 1-bit combinational full adder cell (a, b, cin -> sum, cout)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_bit
  import full_adder_unit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = fa_majority(a, b, cin);

endmodule

`default_nettype wire

// File: rtl/full_adder_unit.sv
// ============================================================================
// full_adder_unit : registered WIDTH-bit ripple-carry adder with valid qualifier
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_unit
  import full_adder_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      fa_bit u_fa (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (w_c[gi]),
        .sum  (w_s[gi]),
        .cout (w_c[gi+1])
      );
    end
  endgenerate

  // Result registers only load on qualified input, so garbage on idle cycles never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_s;
        r_carry <= w_c[WIDTH];
      end
    end
  end

  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_full_adder_unit.sv
// ============================================================================
// tb_full_adder_unit : directed table-driven bench for 1-bit and 8-bit adders
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_full_adder_unit;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;   // {carry, sum}
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic v1, a1, b1, c1;
  logic ov1, s1, co1;

  logic       v8, c8;
  logic [7:0] a8, b8;
  logic       ov8, co8;
  logic [7:0] s8;

  int n_pass  = 0;
  int n_total = 0;

  vec_t t1 [8];
  vec_t t8 [6];

  always #5 clk = ~clk;

  full_adder_unit #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(s1), .carry(co1)
  );

  full_adder_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .sum(s8), .carry(co8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    v8 = v; a8 = a; b8 = b; c8 = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] e;
    logic [7:0] ra, rb;
    logic       rc;

    // WIDTH=1 exhaustive truth table, expected {carry,sum} worked by hand
    t1[0] = '{8'd0, 8'd0, 1'b0, 9'b00};
    t1[1] = '{8'd0, 8'd0, 1'b1, 9'b01};
    t1[2] = '{8'd0, 8'd1, 1'b0, 9'b01};
    t1[3] = '{8'd0, 8'd1, 1'b1, 9'b10};
    t1[4] = '{8'd1, 8'd0, 1'b0, 9'b01};
    t1[5] = '{8'd1, 8'd0, 1'b1, 9'b10};
    t1[6] = '{8'd1, 8'd1, 1'b0, 9'b10};
    t1[7] = '{8'd1, 8'd1, 1'b1, 9'b11};

    t8[0] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    t8[1] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    t8[2] = '{8'hAA, 8'h55, 1'b1, 9'h100};
    t8[3] = '{8'hAA, 8'h55, 1'b0, 9'h0FF};
    t8[4] = '{8'h00, 8'h00, 1'b0, 9'h000};
    t8[5] = '{8'h1E, 8'h1E, 1'b0, 9'h03C};

    rst_n = 1'b0;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v8 = 1'b0; a8 = '0;   b8 = '0;   c8 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_dut1", 64'({ov1, co1, s1}), 64'd0);
    chk("reset_dut8", 64'({ov8, co8, s8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1-bit truth table, back-to-back
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v1 = 1'b1; a1 = t1[i].a[0]; b1 = t1[i].b[0]; c1 = t1[i].cin;
      @(posedge clk);
      #1;
      chk($sformatf("w1_vec%0d", i), 64'({co1, s1}), 64'(t1[i].exp[1:0]));
      chk($sformatf("w1_valid%0d", i), 64'(ov1), 64'd1);
    end
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    @(posedge clk);
    #1;
    chk("w1_valid_drop", 64'(ov1), 64'd0);
    chk("w1_hold", 64'({co1, s1}), 64'b11);

    // 8-bit boundary vectors, back-to-back; the last leaves 0x3C in the register
    for (int i = 0; i < 6; i++) begin
      drive8(1'b1, t8[i].a, t8[i].b, t8[i].cin);
      chk($sformatf("w8_vec%0d", i), 64'({co8, s8}), 64'(t8[i].exp));
      chk($sformatf("w8_valid%0d", i), 64'(ov8), 64'd1);
    end

    // Hold: idle with changing / unknown operands
    drive8(1'b0, 8'hFF, 8'hFF, 1'b1);
    chk("hold0_sum", 64'({co8, s8}), 64'h03C);
    chk("hold0_valid", 64'(ov8), 64'd0);
    drive8(1'b0, 8'h12, 8'h34, 1'b0);
    chk("hold1_sum", 64'({co8, s8}), 64'h03C);
    chk("hold1_valid", 64'(ov8), 64'd0);
    drive8(1'b0, 8'hxx, 8'hxx, 1'bx);
    chk("hold2_sum", 64'({co8, s8}), 64'h03C);
    chk("hold2_valid", 64'(ov8), 64'd0);

    // Asynchronous reset while a result is valid
    drive8(1'b1, 8'h80, 8'h81, 1'b1);
    chk("pre_rst_sum", 64'({co8, s8}), 64'h102);
    chk("pre_rst_valid", 64'(ov8), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 64'({ov8, co8, s8}), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_held", 64'({ov8, co8, s8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v8 = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_no_stale", 64'({ov8, co8, s8}), 64'd0);
    drive8(1'b1, 8'h10, 8'h20, 1'b0);
    chk("post_rst_sum", 64'({co8, s8}), 64'h030);
    chk("post_rst_valid", 64'(ov8), 64'd1);

    // 16 random back-to-back vectors
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      e  = 9'(ra) + 9'(rb) + 9'(rc);
      drive8(1'b1, ra, rb, rc);
      chk($sformatf("rand%0d_sum", i), 64'({co8, s8}), 64'(e));
      chk($sformatf("rand%0d_valid", i), 64'(ov8), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
